// File: rtl/snitch_icache_data_ctrl.sv
// Icache data-array initiator: arbitrates refill writes against lookup reads and returns read lines.
// Define SNITCH_ICACHE_DATA_INIT_EN to zero every line after reset.
module snitch_icache_data_ctrl #(
  parameter int unsigned SET_COUNT   = 2,
  parameter int unsigned LINE_COUNT  = 128,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            lkp_req_valid_i,
  output logic                            lkp_req_ready_o,
  input  logic [COUNT_ALIGN-1:0]          lkp_req_addr_i,
  input  logic [SET_COUNT-1:0]            lkp_req_set_i,
  output logic                            lkp_rsp_valid_o,
  input  logic                            lkp_rsp_ready_i,
  output logic [LINE_WIDTH-1:0]           lkp_rsp_data_o,
  input  logic                            rfl_req_valid_i,
  output logic                            rfl_req_ready_o,
  input  logic [COUNT_ALIGN-1:0]          rfl_req_addr_i,
  input  logic [SET_ALIGN-1:0]            rfl_req_set_i,
  input  logic [LINE_WIDTH-1:0]           rfl_req_data_i,
  output logic [SET_COUNT-1:0]            ram_enable_o,
  output logic                            ram_write_o,
  output logic [COUNT_ALIGN-1:0]          ram_addr_o,
  output logic [SET_COUNT*LINE_WIDTH-1:0] ram_wdata_o,
  input  logic [SET_COUNT*LINE_WIDTH-1:0] ram_rdata_i,
  output logic                            init_busy_o
);

  typedef enum logic [1:0] {IDLE, FRESH, HELD, INIT} state_e;

`ifdef SNITCH_ICACHE_DATA_INIT_EN
  localparam state_e RST_STATE = INIT;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e                 state_q;
  logic [SET_COUNT-1:0]   set_q;
  logic [LINE_WIDTH-1:0]  hold_q;
  logic [LINE_WIDTH-1:0]  line_sel;
  logic [COUNT_ALIGN-1:0] init_q;
  logic [SET_COUNT-1:0]   rfl_sel;
  logic                   rfl_fire;
  logic                   lkp_fire;

`ifdef SNITCH_ICACHE_DATA_INIT_EN
  assign init_busy_o = (state_q == INIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q <= '0;
    end else if (state_q == INIT) begin
      init_q <= init_q + 1'b1;
    end
  end
`else
  assign init_busy_o = 1'b0;
  assign init_q      = '0;
`endif

  assign rfl_req_ready_o = !init_busy_o;
  assign lkp_req_ready_o = !init_busy_o && !rfl_req_valid_i &&
                           (state_q == IDLE || lkp_rsp_ready_i);
  assign rfl_fire = rfl_req_valid_i && rfl_req_ready_o;
  assign lkp_fire = lkp_req_valid_i && lkp_req_ready_o;
  assign rfl_sel  = SET_COUNT'(1) << rfl_req_set_i;

  always_comb begin
    ram_enable_o = '0;
    ram_write_o  = 1'b0;
    ram_addr_o   = '0;
    ram_wdata_o  = {SET_COUNT{rfl_req_data_i}};
    if (init_busy_o) begin
      ram_enable_o = '1;
      ram_write_o  = 1'b1;
      ram_addr_o   = init_q;
      ram_wdata_o  = '0;
    end else if (rfl_fire) begin
      ram_enable_o = rfl_sel;
      ram_write_o  = 1'b1;
      ram_addr_o   = rfl_req_addr_i;
    end else if (lkp_fire) begin
      ram_enable_o = lkp_req_set_i;
      ram_addr_o   = lkp_req_addr_i;
    end
  end

  // OR of enabled slices, so a non-one-hot set still yields defined data
  always_comb begin
    line_sel = '0;
    for (int s = 0; s < int'(SET_COUNT); s++) begin
      if (set_q[s]) line_sel |= ram_rdata_i[s*LINE_WIDTH +: LINE_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      set_q   <= '0;
      hold_q  <= '0;
    end else begin
      if (lkp_fire) set_q <= lkp_req_set_i;
      unique case (state_q)
        IDLE: if (lkp_fire) state_q <= FRESH;
        FRESH, HELD: begin
          if (lkp_rsp_ready_i) begin
            state_q <= lkp_fire ? FRESH : IDLE;
          end else if (state_q == FRESH) begin
            hold_q  <= line_sel;
            state_q <= HELD;
          end
        end
`ifdef SNITCH_ICACHE_DATA_INIT_EN
        INIT: if (init_q == COUNT_ALIGN'(LINE_COUNT - 1)) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lkp_rsp_valid_o = (state_q == FRESH) || (state_q == HELD);
  assign lkp_rsp_data_o  = (state_q == FRESH) ? line_sel :
                           (state_q == HELD)  ? hold_q   : '0;

`ifndef SYNTHESIS
  a_lkp_set_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i)
    lkp_req_valid_i |-> $onehot(lkp_req_set_i)
  );
`endif

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Directed bench for snitch_icache_data_ctrl with a behavioural two-set SRAM.
// Exercises the init sweep too when SNITCH_ICACHE_DATA_INIT_EN is defined.
module tb_snitch_icache_data_ctrl;

`ifdef SNITCH_ICACHE_DATA_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         lkp_v, lkp_rdy, rsp_v, rsp_rdy;
  logic [6:0]   lkp_addr;
  logic [1:0]   lkp_set;
  logic [127:0] rsp_data;
  logic         rfl_v, rfl_rdy;
  logic [6:0]   rfl_addr;
  logic [0:0]   rfl_set;
  logic [127:0] rfl_data;
  logic [1:0]   ram_en;
  logic         ram_we;
  logic [6:0]   ram_addr;
  logic [255:0] ram_wdata;
  logic [255:0] ram_rdata;
  logic         busy;
  logic         load;
  logic [127:0] mem [2][128];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  snitch_icache_data_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .lkp_req_valid_i(lkp_v), .lkp_req_ready_o(lkp_rdy),
    .lkp_req_addr_i(lkp_addr), .lkp_req_set_i(lkp_set),
    .lkp_rsp_valid_o(rsp_v), .lkp_rsp_ready_i(rsp_rdy),
    .lkp_rsp_data_o(rsp_data),
    .rfl_req_valid_i(rfl_v), .rfl_req_ready_o(rfl_rdy),
    .rfl_req_addr_i(rfl_addr), .rfl_req_set_i(rfl_set),
    .rfl_req_data_i(rfl_data),
    .ram_enable_o(ram_en), .ram_write_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .init_busy_o(busy)
  );

  function automatic logic [127:0] pat(input int s, input int a);
    return {4{16'hC0DE, 8'(s), 8'(a)}};
  endfunction

  // SRAM model; a write scrambles the read port so stale data is visible
  always @(posedge clk) begin
    if (load) begin
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < 128; a++) mem[s][a] <= pat(s, a);
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (ram_en[s]) begin
          if (ram_we) begin
            mem[s][ram_addr] <= ram_wdata[s*128 +: 128];
            ram_rdata[s*128 +: 128] <= ~ram_wdata[s*128 +: 128];
          end else begin
            ram_rdata[s*128 +: 128] <= mem[s][ram_addr];
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (busy && n < 300) begin
      tick;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s init_busy stuck got=%b exp=0", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0;
    lkp_v = 0; lkp_addr = '0; lkp_set = '0; rsp_rdy = 0;
    rfl_v = 0; rfl_addr = '0; rfl_set = '0; rfl_data = '0;
    tick; tick; #1;
    checks++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_v); end
    checks++; if (rsp_data !== '0) begin fails++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (ram_en !== {2{INIT_EN}}) begin fails++; $display("FAIL rst_ram_en got=%b exp=%b", ram_en, {2{INIT_EN}}); end
    checks++; if (ram_we !== INIT_EN) begin fails++; $display("FAIL rst_ram_we got=%b exp=%b", ram_we, INIT_EN); end
    checks++; if (ram_addr !== '0) begin fails++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (busy !== INIT_EN) begin fails++; $display("FAIL rst_busy got=%b exp=%b", busy, INIT_EN); end
    tick; rst = 1'b0;
    if (INIT_EN) wait_init("rst");
    tick; load = 1'b1;
    tick; load = 1'b0;
  endtask

  task automatic test_refill_lookup;
    tick; rfl_v = 1; rfl_set = 1'b1; rfl_addr = 7'd5; rfl_data = {16{8'hA5}}; rsp_rdy = 1; #1;
    checks++; if (rfl_rdy !== 1'b1) begin fails++; $display("FAIL rl_rfl_ready got=%b exp=1", rfl_rdy); end
    checks++; if (ram_en !== 2'b10) begin fails++; $display("FAIL rl_wr_en got=%b exp=10", ram_en); end
    checks++; if (ram_we !== 1'b1) begin fails++; $display("FAIL rl_wr_we got=%b exp=1", ram_we); end
    checks++; if (ram_addr !== 7'd5) begin fails++; $display("FAIL rl_wr_addr got=%h exp=5", ram_addr); end
    checks++; if (ram_wdata[255:128] !== {16{8'hA5}}) begin fails++; $display("FAIL rl_wdata got=%h", ram_wdata[255:128]); end
    tick; rfl_v = 0; lkp_v = 1; lkp_set = 2'b10; lkp_addr = 7'd5; #1;
    checks++; if (lkp_rdy !== 1'b1) begin fails++; $display("FAIL rl_lkp_ready got=%b exp=1", lkp_rdy); end
    checks++; if (ram_en !== 2'b10 || ram_we !== 1'b0) begin fails++; $display("FAIL rl_rd_req got=%b/%b exp=10/0", ram_en, ram_we); end
    tick; lkp_v = 0; #1;
    checks++; if (rsp_v !== 1'b1) begin fails++; $display("FAIL rl_rsp_valid got=%b exp=1", rsp_v); end
    checks++; if (rsp_data !== {16{8'hA5}}) begin fails++; $display("FAIL rl_rsp_data got=%h exp=a5..", rsp_data); end
    tick; #1;
    checks++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL rl_rsp_drop got=%b exp=0", rsp_v); end
  endtask

  task automatic test_back_to_back;
    rsp_rdy = 1;
    for (int i = 0; i <= 8; i++) begin
      tick; lkp_v = (i < 8); lkp_set = 2'b01; lkp_addr = 7'(i); #1;
      if (i < 8) begin
        checks++; if (lkp_rdy !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, lkp_rdy); end
      end
      if (i > 0) begin
        checks++;
        if (rsp_v !== 1'b1 || rsp_data !== pat(0, i - 1)) begin
          fails++; $display("FAIL b2b_rsp[%0d] got=%b/%h exp=1/%h", i - 1, rsp_v, rsp_data, pat(0, i - 1));
        end
      end
    end
    lkp_v = 0;
    tick; #1;
    checks++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL b2b_drop got=%b exp=0", rsp_v); end
  endtask

  task automatic test_stall;
    tick; lkp_v = 1; lkp_set = 2'b01; lkp_addr = 7'd12; rsp_rdy = 0; #1;
    checks++; if (lkp_rdy !== 1'b1) begin fails++; $display("FAIL st_accept got=%b exp=1", lkp_rdy); end
    for (int c = 1; c <= 3; c++) begin
      tick; lkp_addr = 7'd13;
      rfl_v = 1; rfl_set = 1'b0; rfl_addr = 7'd12; rfl_data = {16{8'h3C}} ^ 128'(c); #1;
      checks++;
      if (rsp_v !== 1'b1 || rsp_data !== pat(0, 12)) begin
        fails++; $display("FAIL st_hold[%0d] got=%b/%h exp=1/%h", c, rsp_v, rsp_data, pat(0, 12));
      end
      checks++; if (lkp_rdy !== 1'b0) begin fails++; $display("FAIL st_lkp_ready[%0d] got=%b exp=0", c, lkp_rdy); end
    end
    tick; rfl_v = 0; rsp_rdy = 1; #1;
    checks++; if (lkp_rdy !== 1'b1) begin fails++; $display("FAIL st_release_ready got=%b exp=1", lkp_rdy); end
    checks++; if (rsp_data !== pat(0, 12)) begin fails++; $display("FAIL st_release_data got=%h exp=%h", rsp_data, pat(0, 12)); end
    tick; lkp_v = 0; #1;
    checks++; if (rsp_v !== 1'b1 || rsp_data !== pat(0, 13)) begin fails++; $display("FAIL st_next got=%b/%h exp=1/%h", rsp_v, rsp_data, pat(0, 13)); end
    tick; lkp_v = 1; lkp_addr = 7'd12; #1;
    tick; lkp_v = 0; #1;
    checks++;
    if (rsp_data !== ({16{8'h3C}} ^ 128'(3))) begin
      fails++; $display("FAIL st_new_line got=%h exp=%h", rsp_data, {16{8'h3C}} ^ 128'(3));
    end
    tick;
  endtask

  task automatic test_hazard;
    tick; rsp_rdy = 1;
    rfl_v = 1; rfl_set = 1'b1; rfl_addr = 7'd9; rfl_data = {8{16'h9999}};
    lkp_v = 1; lkp_set = 2'b10; lkp_addr = 7'd9; #1;
    checks++; if (rfl_rdy !== 1'b1 || lkp_rdy !== 1'b0) begin fails++; $display("FAIL hz_arb got=%b/%b exp=1/0", rfl_rdy, lkp_rdy); end
    checks++; if (ram_en !== 2'b10 || ram_we !== 1'b1) begin fails++; $display("FAIL hz_wr got=%b/%b exp=10/1", ram_en, ram_we); end
    tick; rfl_v = 0; #1;
    checks++;
    if (lkp_rdy !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 7'd9) begin
      fails++; $display("FAIL hz_rd got=%b/%b/%h exp=1/0/9", lkp_rdy, ram_we, ram_addr);
    end
    tick; lkp_v = 0; #1;
    checks++; if (rsp_v !== 1'b1 || rsp_data !== {8{16'h9999}}) begin fails++; $display("FAIL hz_data got=%b/%h exp=1/9999..", rsp_v, rsp_data); end
    tick;
  endtask

  task automatic test_reset_held;
    tick; lkp_v = 1; lkp_set = 2'b01; lkp_addr = 7'd3; rsp_rdy = 0;
    tick; lkp_v = 0;
    tick; #1;
    checks++; if (rsp_v !== 1'b1 || rsp_data !== pat(0, 3)) begin fails++; $display("FAIL rh_held got=%b/%h exp=1/%h", rsp_v, rsp_data, pat(0, 3)); end
    rst = 1'b1; #1;
    checks++; if (rsp_v !== 1'b0 || rsp_data !== '0) begin fails++; $display("FAIL rh_async got=%b/%h exp=0/0", rsp_v, rsp_data); end
    tick; tick; rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL rh_stale[%0d] got=%b exp=0", c, rsp_v); end
    end
  endtask

  task automatic test_init;
    int n = 0;
    rsp_rdy = 1; lkp_v = 0; rfl_v = 0;
    rst = 1'b1; tick; rst = 1'b0; #1;
    while (busy === 1'b1 && n < 200) begin
      checks++;
      if (ram_en !== 2'b11 || ram_we !== 1'b1 || ram_addr !== 7'(n) || ram_wdata !== '0 ||
          lkp_rdy !== 1'b0 || rfl_rdy !== 1'b0) begin
        fails++; $display("FAIL init_sweep[%0d] got en=%b we=%b addr=%h rdy=%b/%b", n, ram_en, ram_we, ram_addr, lkp_rdy, rfl_rdy);
      end
      n++;
      tick; #1;
    end
    checks++; if (n != 128) begin fails++; $display("FAIL init_cycles got=%0d exp=128", n); end
    tick; lkp_v = 1; lkp_set = 2'b10; lkp_addr = 7'd5; #1;
    tick; lkp_set = 2'b01; lkp_addr = 7'd77; #1;
    checks++; if (rsp_v !== 1'b1 || rsp_data !== '0) begin fails++; $display("FAIL init_rd5 got=%b/%h exp=1/0", rsp_v, rsp_data); end
    tick; lkp_v = 0; #1;
    checks++; if (rsp_v !== 1'b1 || rsp_data !== '0) begin fails++; $display("FAIL init_rd77 got=%b/%h exp=1/0", rsp_v, rsp_data); end
  endtask

  initial begin
    test_reset;
    test_refill_lookup;
    test_back_to_back;
    test_stall;
    test_hazard;
    test_reset_held;
    if (INIT_EN) test_init;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
